// File: rtl/rhythm_decision.sv
// rhythm_decision: debounces per-window normal/AF/VF flags into a confirmed
// rhythm, latches an acknowledgeable alarm and counts AF/VF episodes.
module rhythm_decision #(
    parameter int CONFIRM_AF = 4,
    parameter int CONFIRM_VF = 2,
    parameter int RUN_WIDTH  = 4,
    parameter int EVT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic                 normal,
    input  logic                 AF,
    input  logic                 VF,
    input  logic                 alarm_ack,
    output logic [1:0]           rhythm,
    output logic                 alarm,
    output logic [1:0]           alarm_code,
    output logic                 class_err,
    output logic [EVT_WIDTH-1:0] af_events,
    output logic [EVT_WIDTH-1:0] vf_events
);

    typedef enum logic [1:0] {
        S_NORMAL = 2'b00,
        S_AF     = 2'b01,
        S_VF     = 2'b10
    } state_t;

    localparam logic [RUN_WIDTH:0] CONF_AF = (RUN_WIDTH+1)'(CONFIRM_AF);
    localparam logic [RUN_WIDTH:0] CONF_VF = (RUN_WIDTH+1)'(CONFIRM_VF);

    state_t               state;
    state_t               cand;
    state_t               cand_n;
    state_t               cls;
    logic [RUN_WIDTH-1:0] run;
    logic [RUN_WIDTH-1:0] run_n;
    logic [RUN_WIDTH:0]   run_inc;
    logic [RUN_WIDTH:0]   conf;
    logic                 acc;
    logic                 onehot;
    logic                 go;
    logic                 err_n;
    logic                 into_alarm;

    assign rhythm = state;

    // Decode the window and decide run/candidate update and transition.
    always_comb begin
        acc     = en & in_valid;
        onehot  = ({normal, AF, VF} == 3'b100) ||
                  ({normal, AF, VF} == 3'b010) ||
                  ({normal, AF, VF} == 3'b001);
        cls     = VF ? S_VF : (AF ? S_AF : S_NORMAL);
        conf    = (cls == S_VF) ? CONF_VF : CONF_AF;
        run_inc = {1'b0, run} + 1'b1;
        go      = 1'b0;
        err_n   = 1'b0;
        run_n   = run;
        cand_n  = cand;
        if (acc) begin
            if (!onehot) begin
                err_n  = 1'b1;
                run_n  = '0;
                cand_n = state;
            end else if (cls == state) begin
                run_n  = '0;
                cand_n = state;
            end else if (cls == cand) begin
                if (run_inc == conf) begin
                    go    = 1'b1;
                    run_n = '0;
                end else begin
                    run_n = run_inc[RUN_WIDTH-1:0];
                end
            end else begin
                cand_n = cls;
                if (conf == 1) begin
                    go    = 1'b1;
                    run_n = '0;
                end else begin
                    run_n = RUN_WIDTH'(1);
                end
            end
        end
        into_alarm = go && (cls != S_NORMAL);
    end

    // Rhythm FSM, alarm latch and saturating episode counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_NORMAL;
            cand       <= S_NORMAL;
            run        <= '0;
            alarm      <= 1'b0;
            alarm_code <= 2'b00;
            class_err  <= 1'b0;
            af_events  <= '0;
            vf_events  <= '0;
        end else begin
            class_err <= err_n;
            run       <= run_n;
            cand      <= cand_n;
            if (go) begin
                state <= cls;
            end
            if (go && cls == S_AF && af_events != '1) begin
                af_events <= af_events + 1'b1;
            end
            if (go && cls == S_VF && vf_events != '1) begin
                vf_events <= vf_events + 1'b1;
            end
            if (into_alarm) begin
                alarm <= 1'b1;
                if (alarm_ack || (cls > alarm_code)) begin
                    alarm_code <= cls;
                end
            end else if (alarm_ack) begin
                alarm      <= 1'b0;
                alarm_code <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_rhythm_decision.sv
// tb_rhythm_decision: directed vectors with hand-computed expectations
// for rhythm_decision, plus a narrow-counter build for saturation.
module tb_rhythm_decision;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        in_valid;
    logic        normal;
    logic        AF;
    logic        VF;
    logic        alarm_ack;
    logic [1:0]  rhythm;
    logic        alarm;
    logic [1:0]  alarm_code;
    logic        class_err;
    logic [15:0] af_events;
    logic [15:0] vf_events;
    logic [1:0]  rhythm2;
    logic        alarm2;
    logic [1:0]  alarm_code2;
    logic        class_err2;
    logic [1:0]  af_events2;
    logic [1:0]  vf_events2;

    int errors = 0;
    int checks = 0;

    rhythm_decision dut (
        .clk(clk), .rstn(rstn), .en(en), .in_valid(in_valid),
        .normal(normal), .AF(AF), .VF(VF), .alarm_ack(alarm_ack),
        .rhythm(rhythm), .alarm(alarm), .alarm_code(alarm_code),
        .class_err(class_err), .af_events(af_events),
        .vf_events(vf_events)
    );

    rhythm_decision #(.EVT_WIDTH(2)) dut2 (
        .clk(clk), .rstn(rstn), .en(en), .in_valid(in_valid),
        .normal(normal), .AF(AF), .VF(VF), .alarm_ack(alarm_ack),
        .rhythm(rhythm2), .alarm(alarm2), .alarm_code(alarm_code2),
        .class_err(class_err2), .af_events(af_events2),
        .vf_events(vf_events2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One strobed window; returns at the negedge after the accepting edge.
    task automatic win(input logic n, input logic a, input logic v);
        @(negedge clk);
        in_valid = 1'b1;
        {normal, AF, VF} = {n, a, v};
        @(negedge clk);
        in_valid = 1'b0;
        {normal, AF, VF} = 3'b000;
    endtask

    task automatic wins(input int k, input logic n, input logic a,
                        input logic v);
        for (int i = 0; i < k; i++) win(n, a, v);
    endtask

    task automatic ack();
        @(negedge clk);
        alarm_ack = 1'b1;
        @(negedge clk);
        alarm_ack = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; in_valid = 1'b0;
        normal = 1'b0; AF = 1'b0; VF = 1'b0; alarm_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rhythm", 32'(rhythm), 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_code", 32'(alarm_code), 0);
        chk("rst_err", 32'(class_err), 0);
        chk("rst_af", 32'(af_events), 0);
        chk("rst_vf", 32'(vf_events), 0);
        rstn = 1'b1;

        wins(3, 0, 1, 0);
        chk("af3_rhythm", 32'(rhythm), 0);
        chk("af3_alarm", 32'(alarm), 0);
        win(0, 1, 0);
        chk("af4_rhythm", 32'(rhythm), 1);
        chk("af4_alarm", 32'(alarm), 1);
        chk("af4_code", 32'(alarm_code), 1);
        chk("af4_afev", 32'(af_events), 1);
        ack();
        chk("ack1_alarm", 32'(alarm), 0);
        chk("ack1_code", 32'(alarm_code), 0);
        wins(4, 1, 0, 0);
        chk("norm_rhythm", 32'(rhythm), 0);
        chk("norm_alarm", 32'(alarm), 0);

        win(0, 0, 1);
        chk("vf1_rhythm", 32'(rhythm), 0);
        win(0, 0, 1);
        chk("vf2_rhythm", 32'(rhythm), 2);
        chk("vf2_vfev", 32'(vf_events), 1);
        chk("vf2_code", 32'(alarm_code), 2);
        wins(3, 1, 0, 0);
        chk("vfn3_rhythm", 32'(rhythm), 2);
        win(1, 0, 0);
        chk("vfn4_rhythm", 32'(rhythm), 0);
        chk("vfn4_alarm", 32'(alarm), 1);
        chk("vfn4_code", 32'(alarm_code), 2);
        ack();
        chk("ack2_alarm", 32'(alarm), 0);
        chk("ack2_code", 32'(alarm_code), 0);

        wins(3, 0, 1, 0);
        win(1, 0, 0);
        wins(3, 0, 1, 0);
        chk("intr7_rhythm", 32'(rhythm), 0);
        win(0, 1, 0);
        chk("intr8_rhythm", 32'(rhythm), 1);
        chk("intr8_afev", 32'(af_events), 2);
        ack();
        wins(4, 1, 0, 0);
        chk("intr_back", 32'(rhythm), 0);

        wins(2, 0, 1, 0);
        win(0, 1, 1);
        chk("err_two", 32'(class_err), 1);
        wins(3, 0, 1, 0);
        chk("err_clr", 32'(class_err), 0);
        chk("err_runclr", 32'(rhythm), 0);
        win(0, 0, 0);
        chk("err_none", 32'(class_err), 1);
        chk("err_hold", 32'(rhythm), 0);
        wins(4, 0, 1, 0);
        chk("err_af", 32'(rhythm), 1);
        chk("err_afev", 32'(af_events), 3);

        win(0, 0, 1);
        @(negedge clk);
        alarm_ack = 1'b1;
        in_valid = 1'b1;
        {normal, AF, VF} = 3'b001;
        @(negedge clk);
        alarm_ack = 1'b0;
        in_valid = 1'b0;
        {normal, AF, VF} = 3'b000;
        chk("ackx_rhythm", 32'(rhythm), 2);
        chk("ackx_alarm", 32'(alarm), 1);
        chk("ackx_code", 32'(alarm_code), 2);
        chk("ackx_vfev", 32'(vf_events), 2);
        wins(4, 0, 1, 0);
        chk("vfaf_rhythm", 32'(rhythm), 1);
        chk("vfaf_code", 32'(alarm_code), 2);
        chk("vfaf_afev", 32'(af_events), 4);

        en = 1'b0;
        wins(10, 0, 0, 1);
        chk("en0_rhythm", 32'(rhythm), 1);
        chk("en0_vfev", 32'(vf_events), 2);
        chk("en0_alarm", 32'(alarm), 1);
        ack();
        chk("en0_ack", 32'(alarm), 0);
        chk("en0_code", 32'(alarm_code), 0);
        en = 1'b1;

        wins(4, 1, 0, 0);
        wins(4, 0, 1, 0);
        chk("sat_afev16", 32'(af_events), 5);
        chk("sat_afev2", 32'(af_events2), 3);
        chk("sat_vfev2", 32'(vf_events2), 2);

        win(0, 0, 1);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rhythm", 32'(rhythm), 0);
        chk("mid_alarm", 32'(alarm), 0);
        chk("mid_code", 32'(alarm_code), 0);
        chk("mid_afev", 32'(af_events), 0);
        chk("mid_vfev", 32'(vf_events), 0);
        @(negedge clk);
        rstn = 1'b1;
        win(0, 0, 1);
        chk("mid_run", 32'(rhythm), 0);
        win(0, 0, 1);
        chk("mid_vf", 32'(rhythm), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rhythm_decision.md
Name: rhythm_decision

Overview:
- Consumes the per-window classification flags (normal / AF / VF) from the threshold classifier.
- Debounces them into a confirmed rhythm state using consecutive-window confirmation counts.
- Raises a latched alarm with an acknowledge handshake and keeps saturating AF/VF episode counters.
- Sits between the classifier and the host/alarm interface at the end of the CPSD detection chain.

Parameters:
- CONFIRM_AF, 4, consecutive agreeing valid windows required to enter AF or NORMAL (must be ≥1).
- CONFIRM_VF, 2, consecutive agreeing valid windows required to enter VF (must be ≥1).
- RUN_WIDTH, 4, width of the run counter; must hold max(CONFIRM_AF, CONFIRM_VF).
- EVT_WIDTH, 16, width of the episode counters.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  block enable; when low, in_valid is ignored.
- in_valid  input  1  one-cycle strobe marking a new classification window.
- normal  input  1  classifier flag.
- AF  input  1  classifier flag.
- VF  input  1  classifier flag.
- alarm_ack  input  1  host acknowledge; level sampled each cycle.
- rhythm  output  2  confirmed rhythm: 00 NORMAL, 01 AF, 10 VF. 11 is never driven.
- alarm  output  1  latched alarm.
- alarm_code  output  2  most severe rhythm since the last ack; same encoding as rhythm, 00 when no alarm.
- class_err  output  1  one-cycle pulse on an accepted window whose flags are not one-hot.
- af_events  output  EVT_WIDTH  count of confirmed NORMAL/VF→AF transitions, saturating.
- vf_events  output  EVT_WIDTH  count of confirmed transitions into VF, saturating.

Behaviour:
- Reset (rstn low, asynchronous):
  - rhythm=NORMAL; alarm=0; alarm_code=00; class_err=0; af_events=0; vf_events=0.
  - Internal cand=NORMAL, run=0.
  - Reset mid-episode discards any partial run.
- Accepted window: en=1 and in_valid=1 on a rising edge. All other cycles leave state, cand, run and counters unchanged.
- Class decode:
  - Exactly one flag high → class c.
  - Otherwise: class_err=1 for one cycle, run=0, cand=rhythm. No transition.
- FSM states: NORMAL, AF, VF (state drives rhythm directly). On an accepted valid window with class c:
  - c == rhythm: run=0, cand=rhythm.
  - c != rhythm and c == cand: if run+1 == CONFIRM(c), then transition rhythm=c and run=0; otherwise run=run+1.
  - c != rhythm and c != cand: cand=c, run=1. If CONFIRM(c)==1, transition immediately and set run=0.
  - CONFIRM(VF)=CONFIRM_VF; CONFIRM(AF)=CONFIRM(NORMAL)=CONFIRM_AF.
- Latency: rhythm changes on the same rising edge that accepts the confirming window (visible the cycle after the in_valid cycle). No combinational path from inputs to outputs.
- Transition effects, all on the same edge as the transition:
  - Into AF: af_events+1, saturating at all-ones.
  - Into VF: vf_events+1, saturating at all-ones.
  - Into AF or VF: alarm=1; alarm_code=max(alarm_code, new rhythm), where VF > AF > 00. The code never downgrades while alarm=1.
  - Into NORMAL: no change to alarm or alarm_code. The alarm stays latched until acknowledged.
- Ack:
  - alarm_ack=1 with no transition into AF/VF on the same edge: alarm=0, alarm_code=00.
  - alarm_ack=1 coincident with a transition into AF/VF: the transition wins. alarm stays 1 and alarm_code = the new rhythm (not max'd with the old code).
  - Ack while alarm=0 has no effect.
- en=0: alarm_ack is still honoured; everything else holds.
- Direct rhythm transitions AF↔VF are legal. No detour through NORMAL is required.

Test Plan:
- Reset, then 3 accepted AF windows (CONFIRM_AF=4) → rhythm stays 00, alarm=0. 4th AF window → next cycle rhythm=01, alarm=1, alarm_code=01, af_events=1.
- From NORMAL: 2 VF windows → rhythm=10, vf_events=1, alarm_code=10. Then 4 NORMAL windows → rhythm=00, alarm still 1, alarm_code=10. Then ack → alarm=0, code=00.
- Pattern AF,AF,AF,NORMAL,AF,AF,AF,AF → exactly one transition, on the 8th window. The interrupting NORMAL restarts the run.
- Window with AF=1 and VF=1 → class_err pulse; the partial run is cleared (a following 3 AF windows do not confirm). Window with all flags 0 → class_err pulse.
- In AF with alarm_code=01: alarm_ack asserted on the same edge as the 2nd VF window → alarm=1, alarm_code=10, vf_events incremented. Separately, in VF with alarm_code=10, transition to AF → code stays 10.
- en=0 with in_valid strobes for 10 VF windows → no change. Force af_events to all-ones by 2^EVT_WIDTH episodes (EVT_WIDTH=2 build) → stays 3. Assert rstn low mid-run → all outputs at reset values immediately.
